dco_gen: RTL and testbench

Digitally controlled oscillator model. It is the consuming end of the Clock_adjusting increment/decrement control loop: it takes the increment/decrement corrections and produces the `ring` waveform that the adjuster measures. The block generates a square wave whose half-period is a programmable number of clk cycles. Each correction pulse steps that code with saturation. It replaces the fixed-period ring stimulus in system benches and closes the loop in RTL.

---
 rtl/dco_pkg.sv | 21 ++
 rtl/dco_gen_code_stepper.sv | 34 +++
 rtl/dco_gen.sv | 122 ++++++++++++
 tb/tb_dco_gen.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dco_pkg.sv
// Shared types, widths and helpers for the digitally controlled oscillator.
package dco_pkg;

  localparam int CODE_W   = 8;
  localparam int PERIOD_W = CODE_W + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Limit a requested half-period code to the legal window [lo, hi].
  function automatic int unsigned clamp_code(input int unsigned v,
                                             input int unsigned lo,
                                             input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/dco_gen_code_stepper.sv
// Combinational half-period code stepper with saturation at both bounds.
// Simultaneous increment and decrement cancel out.
module code_stepper #(
  parameter int CODE_W = 8,
  parameter int STEP   = 1
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic [CODE_W-1:0] min_i,
  input  logic [CODE_W-1:0] max_i,
  output logic [CODE_W-1:0] code_o
);

  localparam logic [CODE_W:0] STEP_W = (CODE_W+1)'(STEP);

  logic [CODE_W:0] up_w;
  logic [CODE_W:0] dn_floor_w;

  assign up_w       = {1'b0, code_i} + STEP_W;
  assign dn_floor_w = {1'b0, min_i} + STEP_W;

  // Next code: one step up or down, pinned to the bounds, with a wide
  // intermediate so neither direction can wrap.
  always_comb begin
    code_o = code_i;
    if (inc_i && !dec_i) begin
      code_o = (up_w > {1'b0, max_i}) ? max_i : up_w[CODE_W-1:0];
    end else if (dec_i && !inc_i) begin
      code_o = ({1'b0, code_i} < dn_floor_w) ? min_i : (code_i - STEP_W[CODE_W-1:0]);
    end
  end

endmodule

// File: rtl/dco_gen.sv
// Digitally controlled oscillator: square wave whose half-period is a
// programmable number of clk cycles, nudged by increment/decrement pulses.
// Corrections land immediately in code but only shape the next half-period.
//
// state | meaning
// IDLE  | ring_out held low, code tracks clamped init_code
// RUN   | half-period counter running, code follows correction pulses
module dco_gen
  import dco_pkg::*;
#(
  parameter int CODE_W     = dco_pkg::CODE_W,
  parameter int MIN_CODE   = 2,
  parameter int MAX_CODE   = 255,
  parameter int STEP       = 1,
  parameter int RESET_CODE = 125
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [CODE_W-1:0] init_code,
  input  logic              increment,
  input  logic              decrement,
  output logic              ring_out,
  output logic              rise,
  output logic [CODE_W-1:0] code,
  output logic [CODE_W:0]   period,
  output logic              at_min,
  output logic              at_max
);

  localparam logic [0:0]        S_IDLE  = IDLE;
  localparam logic [0:0]        S_RUN   = RUN;
  localparam logic [CODE_W-1:0] MIN_C   = CODE_W'(MIN_CODE);
  localparam logic [CODE_W-1:0] MAX_C   = CODE_W'(MAX_CODE);
  localparam logic [CODE_W-1:0] RESET_C = CODE_W'(RESET_CODE);
  localparam logic [CODE_W-1:0] ONE_C   = CODE_W'(1);

  logic [0:0]        state_q, state_d;
  logic              ring_q, ring_d;
  logic              rise_q, rise_d;
  logic [CODE_W-1:0] cnt_q, cnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] code_step_w;
  logic [CODE_W-1:0] init_clamped_w;

  assign init_clamped_w = CODE_W'(clamp_code(32'(init_code), 32'(MIN_CODE), 32'(MAX_CODE)));

  code_stepper #(
    .CODE_W (CODE_W),
    .STEP   (STEP)
  ) u_stepper (
    .code_i (code_q),
    .inc_i  (increment),
    .dec_i  (decrement),
    .min_i  (MIN_C),
    .max_i  (MAX_C),
    .code_o (code_step_w)
  );

  // Next-state logic: FSM, half-period counter, waveform and code update.
  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    rise_d  = 1'b0;
    cnt_d   = cnt_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        ring_d = 1'b0;
        if (!ld) begin
          code_d = init_clamped_w;
        end else begin
          state_d = S_RUN;
          cnt_d   = code_q - ONE_C;
        end
      end
      S_RUN: begin
        if (!ld) begin
          state_d = S_IDLE;
          ring_d  = 1'b0;
          cnt_d   = '0;
          code_d  = init_clamped_w;
        end else begin
          code_d = code_step_w;
          if (cnt_q == '0) begin
            ring_d = ~ring_q;
            rise_d = ~ring_q;
            cnt_d  = code_step_w - ONE_C;
          end else begin
            cnt_d = cnt_q - ONE_C;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset drops the waveform immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ring_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
      code_q  <= RESET_C;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
    end
  end

  assign ring_out = ring_q;
  assign rise     = rise_q;
  assign code     = code_q;
  assign period   = {code_q, 1'b0};
  assign at_min   = (code_q == MIN_C);
  assign at_max   = (code_q == MAX_C);

endmodule

// File: tb/tb_dco_gen.sv
// Directed bench for dco_gen: waveform timing, correction, saturation,
// exit/re-entry and asynchronous reset.
module tb_dco_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld;
  logic [7:0] init_code;
  logic       increment;
  logic       decrement;
  logic       ring_out;
  logic       rise;
  logic [7:0] code;
  logic [8:0] period;
  logic       at_min;
  logic       at_max;

  int checks = 0;
  int errors = 0;

  dco_gen dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .init_code (init_code),
    .increment (increment),
    .decrement (decrement),
    .ring_out  (ring_out),
    .rise      (rise),
    .code      (code),
    .period    (period),
    .at_min    (at_min),
    .at_max    (at_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; init_code = 8'd4; increment = 1'b0; decrement = 1'b0;
    #2;
    chk("rst_code",   32'(code),     32'd125);
    chk("rst_period", 32'(period),   32'd250);
    chk("rst_ring",   32'(ring_out), 32'd0);
    chk("rst_rise",   32'(rise),     32'd0);
    chk("rst_at_min", 32'(at_min),   32'd0);
    chk("rst_at_max", 32'(at_max),   32'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_code",   32'(code),     32'd4);
    chk("idle_period", 32'(period),   32'd8);
    chk("idle_ring",   32'(ring_out), 32'd0);

    // Plan 1: code 4 -> low 4, high 4, rise on first high cycle.
    ld = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      chk($sformatf("run4_ring_%0d", i), 32'(ring_out), 32'((i / 4) % 2));
      chk($sformatf("run4_rise_%0d", i), 32'(rise),     32'((i % 8) == 4));
    end

    // Plan 2: increment in second cycle of the high phase.
    increment = 1'b1;
    step();
    increment = 1'b0;
    chk("inc_code",   32'(code),     32'd5);
    chk("inc_period", 32'(period),   32'd10);
    chk("inc_ring",   32'(ring_out), 32'd1);
    for (int j = 1; j < 8; j++) begin
      step();
      chk($sformatf("inc_ring_%0d", j), 32'(ring_out), (j < 2) ? 32'd1 : ((j < 7) ? 32'd0 : 32'd1));
      chk($sformatf("inc_rise_%0d", j), 32'(rise),     32'(j == 7));
    end

    // Plan 4: both pulses held for 5 cycles cancel.
    increment = 1'b1; decrement = 1'b1;
    for (int m = 1; m <= 5; m++) begin
      step();
      chk($sformatf("both_code_%0d", m), 32'(code),     32'd5);
      chk($sformatf("both_ring_%0d", m), 32'(ring_out), 32'(m < 5));
    end
    increment = 1'b0; decrement = 1'b0;

    // Plan 3: saturation at MAX, then clamp to MIN.
    ld = 1'b0; init_code = 8'd254;
    step();
    chk("ld0_ring", 32'(ring_out), 32'd0);
    chk("ld0_code", 32'(code),     32'd254);
    ld = 1'b1;
    step();
    increment = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk($sformatf("max_code_%0d", n),   32'(code),   32'd255);
      chk($sformatf("max_at_max_%0d", n), 32'(at_max), 32'd1);
    end
    increment = 1'b0;
    ld = 1'b0; init_code = 8'd0;
    step();
    chk("min_clamp_code", 32'(code),   32'd2);
    chk("min_at_min",     32'(at_min), 32'd1);
    chk("min_at_max",     32'(at_max), 32'd0);
    chk("min_period",     32'(period), 32'd4);
    ld = 1'b1;
    step();
    decrement = 1'b1;
    step();
    decrement = 1'b0;
    chk("min_dec_code",   32'(code),     32'd2);
    chk("min_dec_at_min", 32'(at_min),   32'd1);
    chk("min_dec_ring",   32'(ring_out), 32'd0);
    step();
    chk("min_hi_ring", 32'(ring_out), 32'd1);
    chk("min_hi_rise", 32'(rise),     32'd1);

    // Plan 5: drop ld in the middle of a high phase, then re-enter.
    ld = 1'b0; init_code = 8'd7;
    step();
    chk("exit_ring", 32'(ring_out), 32'd0);
    chk("exit_rise", 32'(rise),     32'd0);
    chk("exit_code", 32'(code),     32'd7);
    ld = 1'b1;
    for (int p = 0; p < 8; p++) begin
      step();
      chk($sformatf("reent_ring_%0d", p), 32'(ring_out), 32'(p == 7));
      chk($sformatf("reent_rise_%0d", p), 32'(rise),     32'(p == 7));
    end

    // Plan 6: async reset between edges while ring_out is high.
    #2 rst = 1'b1;
    #1;
    chk("arst_ring",   32'(ring_out), 32'd0);
    chk("arst_rise",   32'(rise),     32'd0);
    chk("arst_code",   32'(code),     32'd125);
    chk("arst_period", 32'(period),   32'd250);
    ld = 1'b0;
    step();
    chk("arst_hold_rise", 32'(rise),     32'd0);
    chk("arst_hold_ring", 32'(ring_out), 32'd0);
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
